// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables and pure byte/column transforms used by
// the inverse cipher and its key store.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } aes_state_e;

  function automatic int nk_of(input int size);
    return size / 32;
  endfunction

  function automatic int nr_of(input int size);
    return size / 32 + 6;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Entry 0 sits in the top byte, so byte b lives at bits {~b,3'b111} down.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index is 4*col+row; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_store.sv
// Round-key store: holds the full expanded schedule and produces one new
// schedule word per 'next' cycle after a key load.
module aes_key_store
  import aes_pkg::*;
#(
  parameter int size = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [size-1:0] key,
  input  logic            next,
  output logic            free,
  input  logic [3:0]      rd_round,
  output logic [127:0]    rd_key
);

  localparam int NK = nk_of(size);
  localparam int NR = nr_of(size);
  localparam int NW = 4 * (NR + 1);

  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [5:0]  j_q, j_d;
  logic [2:0]  pos_q, pos_d;
  logic [3:0]  rci_q, rci_d;
  logic [31:0] prev_w, base_w, t_w;
  logic [5:0]  rd_idx;

  // pos_q tracks j mod Nk and rci_q tracks j/Nk-1, avoiding a divider.
  always_comb begin
    prev_w = w_q[j_q - 6'd1];
    base_w = w_q[j_q - 6'(NK)];
    if (pos_q == 3'd0) begin
      t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon(rci_q), 24'h000000};
    end else if (NK == 8 && pos_q == 3'd4) begin
      t_w = sub_word(prev_w);
    end else begin
      t_w = prev_w;
    end
  end

  always_comb begin
    w_d   = w_q;
    j_d   = j_q;
    pos_d = pos_q;
    rci_d = rci_q;
    if (load) begin
      for (int i = 0; i < NK; i++) w_d[i] = key[size-1-32*i -: 32];
      j_d   = 6'(NK);
      pos_d = 3'd0;
      rci_d = 4'd0;
    end else if (next && j_q != 6'(NW)) begin
      w_d[j_q] = base_w ^ t_w;
      j_d      = j_q + 6'd1;
      if (pos_q == 3'(NK - 1)) begin
        pos_d = 3'd0;
        rci_d = rci_q + 4'd1;
      end else begin
        pos_d = pos_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_q   <= 6'(NW);
      pos_q <= 3'd0;
      rci_q <= 4'd0;
    end else begin
      j_q   <= j_d;
      pos_q <= pos_d;
      rci_q <= rci_d;
    end
  end

  // High while the final word is being written, so the caller can leave
  // expansion on that same edge.
  assign free = (j_q >= 6'(NW - 1));

  assign rd_idx = {rd_round, 2'b00};
  assign rd_key = {w_q[rd_idx], w_q[rd_idx + 6'd1], w_q[rd_idx + 6'd2], w_q[rd_idx + 6'd3]};

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: expand the key schedule, then run one inverse
// round per clock from the last round key down to round key 0.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int size = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [127:0]    ciphertext,
  input  logic [size-1:0] key,
  output logic [127:0]    plaintext,
  output logic            busy,
  output logic            done
);

  localparam int NR = nr_of(size);

  if (size != 128 && size != 192 && size != 256) begin : g_size_chk
    $error("aes_inv_cipher: size must be 128, 192 or 256");
  end

  aes_state_e   state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         ks_load, ks_next, ks_free;
  logic [127:0] rk;
  logic [127:0] sr_sb;

  aes_key_store #(.size(size)) u_key_store (
    .clk      (clk),
    .reset    (reset),
    .load     (ks_load),
    .key      (key),
    .next     (ks_next),
    .free     (ks_free),
    .rd_round (rnd_q),
    .rd_key   (rk)
  );

  assign sr_sb = inv_sub_bytes(inv_shift_rows(st_q));

  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    st_d    = st_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ks_load = 1'b0;
    ks_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ct_d    = ciphertext;
          ks_load = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        ks_next = 1'b1;
        if (ks_free) begin
          rnd_d   = 4'(NR);
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        st_d    = ct_q ^ rk;
        rnd_d   = rnd_q - 4'd1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        st_d  = inv_mix_columns(sr_sb ^ rk);
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        pt_d    = sr_sb ^ rk;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ct_q    <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      rnd_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher at all three key sizes: known answers, handshake
// corner cases and random blocks encrypted by an in-bench forward AES model.
module tb_aes_inv_cipher;

  logic         clk;
  logic         reset;
  logic         start_a [3];
  logic [127:0] ct_a    [3];
  logic [255:0] key_a   [3];
  logic [127:0] pt_a    [3];
  logic         busy_a  [3];
  logic         done_a  [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_cipher #(.size(128 + 64*g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_a[g]),
      .ciphertext (ct_a[g]),
      .key        (key_a[g][255 -: 128 + 64*g]),
      .plaintext  (pt_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: forward AES from first principles ----
  function automatic int gf_mul(input int a, input int b);
    int p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word_m(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key,
                                           input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [127:0] o;
    int           nr, rc;
    nr = nk + 6;
    rc = 1;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = sub_word_m(tmp) ^ {8'(rc), 24'h0};
        rc  = gf_mul(rc, 2);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word_m(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= nr; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
          if (r < nr) begin
            s[4*c]   = 8'(gf_mul(t[4*c], 2) ^ gf_mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3]);
            s[4*c+1] = 8'(t[4*c] ^ gf_mul(t[4*c+1], 2) ^ gf_mul(t[4*c+2], 3) ^ t[4*c+3]);
            s[4*c+2] = 8'(t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 2) ^ gf_mul(t[4*c+3], 3));
            s[4*c+3] = 8'(gf_mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 2));
          end else begin
            for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = s[4*c+rr] ^ w[4*r+c][31-8*rr -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int lat_of(input int k);
    int nk, nr;
    nk = 4 + 2*k;
    nr = nk + 6;
    return 4*(nr+1) - nk + nr + 1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // One operation on instance k; restart_at pulses an ignored start mid-run.
  task automatic run_op(input int k, input logic [127:0] ct, input logic [255:0] key,
                        input logic [127:0] exp_pt, input int restart_at, input string tag);
    int n;
    bit seen, busy_ok;
    @(negedge clk);
    start_a[k] = 1'b1;
    ct_a[k]    = ct;
    key_a[k]   = key;
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    ct_a[k]    = rand128();
    key_a[k]   = rand256();
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (n == restart_at) begin
        start_a[k] = 1'b1;
        ct_a[k]    = '0;
      end else if (n == restart_at + 1) begin
        start_a[k] = 1'b0;
      end
      @(negedge clk);
      if (done_a[k]) seen = 1;
      else if (!busy_a[k]) busy_ok = 0;
    end
    chk({tag, " latency"}, n, lat_of(k));
    chk({tag, " busy_held"}, busy_ok, 1);
    chk({tag, " busy_end"}, busy_a[k], 0);
    chk({tag, " plaintext"}, pt_a[k], exp_pt);
  endtask

  task automatic abort_op(input int k);
    bit seen;
    @(negedge clk);
    start_a[k] = 1'b1;
    ct_a[k]    = rand128();
    key_a[k]   = rand256();
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a[k]) seen = 1;
    end
    reset = 1'b0;
    #1;
    chk("abort no_done", seen, 0);
    chk("abort plaintext", pt_a[k], 0);
    chk("abort busy", busy_a[k], 0);
    chk("abort done", done_a[k], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic b2b_ops(input int k);
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    logic [255:0] key;
    int n, last, ndone;
    bit swap;
    key = rand256();
    for (int i = 0; i < 4; i++) begin
      pts[i] = rand128();
      cts[i] = aes_enc(pts[i], key, 4 + 2*k);
    end
    @(negedge clk);
    start_a[k] = 1'b1;
    ct_a[k]    = cts[0];
    key_a[k]   = key;
    @(posedge clk);
    #1;
    ct_a[k] = cts[1];
    n = 0; last = 0; ndone = 0; swap = 0;
    while (ndone < 3 && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (swap) begin
        ct_a[k] = cts[ndone + 1];
        swap = 0;
      end
      @(negedge clk);
      if (done_a[k]) begin
        chk($sformatf("b2b gap%0d", ndone), n - last, (ndone == 0) ? lat_of(k) : lat_of(k) + 1);
        chk($sformatf("b2b pt%0d", ndone), pt_a[k], pts[ndone]);
        last = n;
        ndone++;
        swap = 1;
        if (ndone == 3) start_a[k] = 1'b0;
      end
    end
    chk("b2b completed", ndone, 3);
    start_a[k] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] pt, ct;
    logic [255:0] key;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      ct_a[k]    = '0;
      key_a[k]   = '0;
    end
    for (int x = 0; x < 256; x++) begin
      int inv, s;
      inv = 0;
      for (int y = 1; y < 256; y++) if (gf_mul(x, y) == 1) inv = y;
      s = inv;
      for (int n = 1; n < 5; n++) s = s ^ (((inv << n) | (inv >> (8 - n))) & 'hff);
      sb[x] = 8'(s ^ 'h63);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst plaintext%0d", k), pt_a[k], 0);
      chk($sformatf("rst busy%0d", k), busy_a[k], 0);
      chk($sformatf("rst done%0d", k), done_a[k], 0);
    end
    reset = 1'b1;

    run_op(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, KAT_PT, -1, "kat128");
    run_op(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
           {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, KAT_PT, -1, "kat192");
    run_op(2, 128'h8ea2b7ca516745bfeafc49904b496089,
           256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
           KAT_PT, -1, "kat256");

    run_op(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, KAT_PT, 10, "ignore_start");

    abort_op(0);
    pt  = rand128();
    key = rand256();
    ct  = aes_enc(pt, key, 4);
    run_op(0, ct, key, pt, -1, "after_abort");

    b2b_ops(0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        pt  = rand128();
        key = rand256();
        ct  = aes_enc(pt, key, 4 + 2*k);
        run_op(k, ct, key, pt, -1, $sformatf("rand%0d_%0d", 128 + 64*k, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
